// File: rtl/den_giao_thong.sv
// Two-way intersection traffic-light controller.
// A prescaler turns clk into a one-second tick; a four-phase FSM steps
// green -> yellow for direction 1, then green -> yellow for direction 2,
// holding the other direction on red. Lamps and the tick strobe are registered.
//
//   state | meaning
//   S0    | dir1 go   : G1 + R2, lasts GREEN_T ticks
//   S1    | dir1 warn : Y1 + R2, lasts YELLOW_T ticks
//   S2    | dir2 go   : R1 + G2, lasts GREEN_T ticks
//   S3    | dir2 warn : R1 + Y2, lasts YELLOW_T ticks
module den_giao_thong #(
   parameter int unsigned CLK_DIV  = 50000000,
   parameter int unsigned GREEN_T  = 25,
   parameter int unsigned YELLOW_T = 3
) (
   input  logic       clk,
   input  logic       rst,
   output logic       dem,
   output logic [5:0] LED
);

   typedef enum logic [1:0] {S0, S1, S2, S3} phase_t;

   localparam logic [31:0] PRE_LAST = 32'(CLK_DIV - 1);
   localparam logic [7:0]  SEC_G    = 8'(GREEN_T - 1);
   localparam logic [7:0]  SEC_Y    = 8'(YELLOW_T - 1);

   localparam logic [5:0] LED_S0 = 6'b001100;
   localparam logic [5:0] LED_S1 = 6'b010100;
   localparam logic [5:0] LED_S2 = 6'b100001;
   localparam logic [5:0] LED_S3 = 6'b100010;

   logic [31:0] pre;
   logic [7:0]  sec;
   phase_t      phase;
   phase_t      phase_nxt;
   logic [7:0]  sec_load;
   logic [5:0]  led_nxt;
   logic        tick;

   assign tick = (pre == PRE_LAST);

   // Next phase in the fixed rotation plus its reload value and lamp pattern;
   // any unexpected encoding falls back to S0.
   always_comb begin
      phase_nxt = S0;
      sec_load  = SEC_G;
      led_nxt   = LED_S0;
      case (phase)
         S0: begin phase_nxt = S1; sec_load = SEC_Y; led_nxt = LED_S1; end
         S1: begin phase_nxt = S2; sec_load = SEC_G; led_nxt = LED_S2; end
         S2: begin phase_nxt = S3; sec_load = SEC_Y; led_nxt = LED_S3; end
         S3: begin phase_nxt = S0; sec_load = SEC_G; led_nxt = LED_S0; end
         default: begin phase_nxt = S0; sec_load = SEC_G; led_nxt = LED_S0; end
      endcase
   end

   // Prescaler, phase countdown, FSM and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pre   <= '0;
         sec   <= SEC_G;
         phase <= S0;
         LED   <= LED_S0;
         dem   <= 1'b0;
      end else begin
         dem <= tick;
         if (tick) begin
            pre <= '0;
            if (sec == 8'd0) begin
               phase <= phase_nxt;
               sec   <= sec_load;
               LED   <= led_nxt;
            end else begin
               sec <= sec - 8'd1;
            end
         end else begin
            pre <= pre + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_den_giao_thong.sv
// Bench for den_giao_thong: three instances (small periods, every-edge tick,
// default parameters) share clk/rst. A time-based model predicts lamps and
// tick strobe from the number of edges since the last reset edge.
module tb_den_giao_thong;

   logic       clk;
   logic       rst;
   logic       dem_a, dem_b, dem_c;
   logic [5:0] led_a, led_b, led_c;

   int checks = 0;
   int errors = 0;
   int k      = 0;
   bit seen   = 0;

   den_giao_thong #(.CLK_DIV(4), .GREEN_T(3), .YELLOW_T(2)) dut_a (
      .clk(clk), .rst(rst), .dem(dem_a), .LED(led_a));
   den_giao_thong #(.CLK_DIV(1), .GREEN_T(1), .YELLOW_T(1)) dut_b (
      .clk(clk), .rst(rst), .dem(dem_b), .LED(led_b));
   den_giao_thong dut_c (
      .clk(clk), .rst(rst), .dem(dem_c), .LED(led_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", name, act, exp, k, $time);
      end
   endtask

   // Lamp pattern after k edges since reset: whole ticks elapsed, folded
   // into one full cycle of 2*(G+Y) ticks.
   function automatic logic [5:0] exp_led(input int kk, input int cd, input int g, input int y);
      int t, p;
      t = kk / cd;
      p = t % (2 * (g + y));
      if (p < g)              return 6'b001100;
      else if (p < g + y)     return 6'b010100;
      else if (p < 2 * g + y) return 6'b100001;
      else                    return 6'b100010;
   endfunction

   function automatic logic exp_dem(input int kk, input int cd);
      return (kk > 0) && (kk % cd == 0);
   endfunction

   // Edges with rst high since the last reset edge.
   always @(posedge clk) begin
      if (!rst) k <= 0;
      else      k <= k + 1;
      seen <= 1'b1;
   end

   // Per-cycle comparison against the model plus lamp safety rules.
   always @(negedge clk) begin
      if (seen) begin
         check("led_a", int'(led_a), int'(exp_led(k, 4, 3, 2)));
         check("dem_a", int'(dem_a), int'(exp_dem(k, 4)));
         check("led_b", int'(led_b), int'(exp_led(k, 1, 1, 1)));
         check("dem_b", int'(dem_b), int'(exp_dem(k, 1)));
         check("led_c", int'(led_c), int'(exp_led(k, 50000000, 25, 3)));
         check("dem_c", int'(dem_c), int'(exp_dem(k, 50000000)));
         check("onehot_dir1", int'($countones(led_a[5:3])), 1);
         check("onehot_dir2", int'($countones(led_a[2:0])), 1);
         check("no_dual_go", int'(!led_a[5] && !led_a[2]), 0);
      end
   end

   initial begin
      int pulses;
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("hold_led", int'(led_a), 'h0C);
      check("hold_dem", int'(dem_a), 0);
      rst = 1'b1;

      pulses = 0;
      for (int e = 1; e <= 120; e++) begin
         @(negedge clk);
         if (dem_a) pulses++;
         if (e == 4)  check("dem_edge4", int'(dem_a), 1);
         if (e == 5)  check("dem_edge5", int'(dem_a), 0);
         if (e == 11) check("lit_e11", int'(led_a), 'b001100);
         if (e == 12) check("lit_e12", int'(led_a), 'b010100);
         if (e == 20) check("lit_e20", int'(led_a), 'b100001);
         if (e == 32) check("lit_e32", int'(led_a), 'b100010);
         if (e == 40) check("lit_e40", int'(led_a), 'b001100);
         if (e == 1)  check("b_e1", int'(led_b), 'b010100);
         if (e == 2)  check("b_e2", int'(led_b), 'b100001);
         if (e == 3)  check("b_e3", int'(led_b), 'b100010);
         if (e == 4)  check("b_e4", int'(led_b), 'b001100);
         if (e <= 4)  check("b_dem", int'(dem_b), 1);
      end
      check("dem_pulses", pulses, 30);

      repeat (22) @(negedge clk);
      check("mid_s2", int'(led_a), 'b100001);
      rst = 1'b0;
      @(negedge clk);
      check("rst_led", int'(led_a), 'b001100);
      check("rst_dem", int'(dem_a), 0);
      rst = 1'b1;
      repeat (11) @(negedge clk);
      check("rel_e11", int'(led_a), 'b001100);
      @(negedge clk);
      check("rel_e12", int'(led_a), 'b010100);

      repeat (40) begin
         repeat ($urandom_range(1, 80)) @(negedge clk);
         rst = 1'b0;
         repeat ($urandom_range(1, 3)) @(negedge clk);
         rst = 1'b1;
      end
      repeat (50) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
